// File: rtl/uart_hex_loader.sv
// uart_hex_loader: 8N1 UART receiver that assembles ASCII hex digits into a
// 16-bit display value. '.' clears the value. A stop bit sampled low raises
// frame_err and parks the receiver until the line returns high.
`timescale 1ns/1ps
module uart_hex_loader #(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned BAUD   = 115200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rxd,
  output logic [15:0] value,
  output logic        update,
  output logic        frame_err
);

  localparam int unsigned DIV  = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int unsigned HALF = DIV / 2;
  localparam int unsigned CW   = $clog2(DIV);

  localparam logic [CW-1:0] CNT_FULL = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            sync1;
  logic            sync2;
  logic            rs;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nxt;
  logic [2:0]      bidx;
  logic [2:0]      bidx_nxt;
  logic [7:0]      shreg;
  logic [7:0]      shreg_nxt;
  logic [15:0]     value_nxt;
  logic            update_nxt;
  logic            frame_err_nxt;
  logic            tick_c;
  logic [4:0]      dec_c;

  // Map an ASCII hex character to {valid, nibble}
  function automatic logic [4:0] hex_decode(input logic [7:0] b);
    logic [4:0] r;
    r = 5'd0;
    if (b >= 8'h30 && b <= 8'h39) begin
      r = {1'b1, b[3:0]};
    end else if ((b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66)) begin
      r = {1'b1, 4'(b[3:0] + 4'd9)};
    end
    return r;
  endfunction

  // Two-flop synchronizer for the asynchronous receive pin, idle high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= rxd;
      sync2 <= sync1;
    end
  end

  assign rs     = sync2;
  assign tick_c = (cnt == '0);
  assign dec_c  = hex_decode(shreg);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: frame sequencing on sample ticks
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (!rs) state_nxt = S_START;
      end
      S_START: begin
        if (tick_c) state_nxt = rs ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (tick_c && bidx == 3'd7) state_nxt = S_STOP;
      end
      S_STOP: begin
        if (tick_c) state_nxt = rs ? S_IDLE : S_BREAK;
      end
      S_BREAK: begin
        if (rs) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic: counter, shifter, decode and strobe next values
  always_comb begin
    cnt_nxt       = cnt;
    bidx_nxt      = bidx;
    shreg_nxt     = shreg;
    value_nxt     = value;
    update_nxt    = 1'b0;
    frame_err_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rs) cnt_nxt = CNT_HALF;
      end
      S_START: begin
        if (tick_c) begin
          cnt_nxt  = CNT_FULL;
          bidx_nxt = 3'd0;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      S_DATA: begin
        if (tick_c) begin
          shreg_nxt = {rs, shreg[7:1]};
          cnt_nxt   = CNT_FULL;
          bidx_nxt  = bidx + 3'd1;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      S_STOP: begin
        if (tick_c) begin
          if (rs) begin
            if (dec_c[4]) begin
              value_nxt  = {value[11:0], dec_c[3:0]};
              update_nxt = 1'b1;
            end else if (shreg == 8'h2E) begin
              value_nxt  = 16'h0000;
              update_nxt = 1'b1;
            end
          end else begin
            frame_err_nxt = 1'b1;
          end
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: begin
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      bidx      <= 3'd0;
      shreg     <= 8'h00;
      value     <= 16'h0000;
      update    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      bidx      <= bidx_nxt;
      shreg     <= shreg_nxt;
      value     <= value_nxt;
      update    <= update_nxt;
      frame_err <= frame_err_nxt;
    end
  end

endmodule

// File: tb/tb_uart_hex_loader.sv
// Testbench for uart_hex_loader: table of frames with expected results plus
// hand-written glitch and mid-frame reset sequences, checked via a scoreboard.
`timescale 1ns/1ps
module tb_uart_hex_loader;

  localparam int unsigned CLK_HZ = 1_000_000;
  localparam int unsigned BAUD   = 100_000;
  localparam int unsigned DIV    = 10;
  localparam int unsigned NVEC   = 18;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rxd = 1'b1;
  logic [15:0] value;
  logic        update;
  logic        frame_err;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0]  ch;
    logic        stop;
    int unsigned tail_low;
    int unsigned gap;
    logic        exp_upd;
    logic        exp_ferr;
    logic [15:0] exp_value;
  } vec_t;

  typedef struct {
    logic        is_ferr;
    logic [15:0] value;
  } ev_t;

  vec_t vecs [NVEC];
  ev_t  exp_q [$];

  uart_hex_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rxd       (rxd),
    .value     (value),
    .update    (update),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one 8N1 frame starting at a falling clock edge; optionally keep the
  // line low for tail_low extra cycles after the stop bit.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int unsigned tail_low);
    rxd = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (DIV) @(negedge clk);
    end
    rxd = stop;
    repeat (DIV + tail_low) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic push_ev(input logic is_ferr, input logic [15:0] v);
    ev_t e;
    e.is_ferr = is_ferr;
    e.value   = v;
    exp_q.push_back(e);
  endtask

  // Scoreboard: every strobe must match the next expected event
  always @(negedge clk) begin
    if (update === 1'b1 || frame_err === 1'b1) begin
      check1("strobe_exclusive", update & frame_err, 1'b0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event: got update=%b frame_err=%b value=%h expected no event at %0t",
                 update, frame_err, value, $time);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        check1("event_kind_ferr", frame_err, e.is_ferr);
        check16("event_value", value, e.value);
      end
    end
  end

  initial begin
    vecs[0]  = '{8'h31, 1'b1, 0, 20, 1'b1, 1'b0, 16'h0001};
    vecs[1]  = '{8'h32, 1'b1, 0, 20, 1'b1, 1'b0, 16'h0012};
    vecs[2]  = '{8'h33, 1'b1, 0, 20, 1'b1, 1'b0, 16'h0123};
    vecs[3]  = '{8'h34, 1'b1, 0, 20, 1'b1, 1'b0, 16'h1234};
    vecs[4]  = '{8'h61, 1'b1, 0,  0, 1'b1, 1'b0, 16'h234A};
    vecs[5]  = '{8'h42, 1'b1, 0,  0, 1'b1, 1'b0, 16'h34AB};
    vecs[6]  = '{8'h63, 1'b1, 0,  0, 1'b1, 1'b0, 16'h4ABC};
    vecs[7]  = '{8'h44, 1'b1, 0,  0, 1'b1, 1'b0, 16'hABCD};
    vecs[8]  = '{8'h65, 1'b1, 0, 20, 1'b1, 1'b0, 16'hBCDE};
    vecs[9]  = '{8'h31, 1'b1, 0, 20, 1'b1, 1'b0, 16'hCDE1};
    vecs[10] = '{8'h32, 1'b1, 0, 20, 1'b1, 1'b0, 16'hDE12};
    vecs[11] = '{8'h33, 1'b1, 0, 20, 1'b1, 1'b0, 16'hE123};
    vecs[12] = '{8'h34, 1'b1, 0, 20, 1'b1, 1'b0, 16'h1234};
    vecs[13] = '{8'h2E, 1'b1, 0, 20, 1'b1, 1'b0, 16'h0000};
    vecs[14] = '{8'h47, 1'b1, 0, 20, 1'b0, 1'b0, 16'h0000};
    vecs[15] = '{8'h41, 1'b1, 0, 20, 1'b1, 1'b0, 16'h000A};
    vecs[16] = '{8'h37, 1'b0, 30, 20, 1'b0, 1'b1, 16'h000A};
    vecs[17] = '{8'h35, 1'b1, 0, 20, 1'b1, 1'b0, 16'h00A5};

    rst_n = 1'b0;
    rxd   = 1'b1;
    repeat (3) @(negedge clk);
    check16("reset_value", value, 16'h0000);
    check1("reset_update", update, 1'b0);
    check1("reset_frame_err", frame_err, 1'b0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < int'(NVEC); i++) begin
      if (vecs[i].exp_upd)  push_ev(1'b0, vecs[i].exp_value);
      if (vecs[i].exp_ferr) push_ev(1'b1, vecs[i].exp_value);
      send_frame(vecs[i].ch, vecs[i].stop, vecs[i].tail_low);
      repeat (vecs[i].gap) @(negedge clk);
      check16($sformatf("vec%0d_value", i), value, vecs[i].exp_value);
    end

    // Short low glitch in idle must be rejected, then '9' received
    rxd = 1'b0;
    repeat (3) @(negedge clk);
    rxd = 1'b1;
    repeat (20) @(negedge clk);
    check16("glitch_value", value, 16'h00A5);
    push_ev(1'b0, 16'h0A59);
    send_frame(8'h39, 1'b1, 0);
    repeat (20) @(negedge clk);
    check16("after_glitch_value", value, 16'h0A59);

    // '3', then reset during data bit 4 of the following frame, then '8'
    push_ev(1'b0, 16'hA593);
    send_frame(8'h33, 1'b1, 0);
    repeat (20) @(negedge clk);
    check16("pre_reset_value", value, 16'hA593);
    begin
      logic [7:0] b;
      b = 8'h38;
      rxd = 1'b0;
      repeat (DIV) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        rxd = b[i];
        repeat (DIV) @(negedge clk);
      end
      rxd = b[4];
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check16("midreset_value", value, 16'h0000);
      check1("midreset_update", update, 1'b0);
      check1("midreset_frame_err", frame_err, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      rxd = 1'b1;
    end
    repeat (60) @(negedge clk);
    check16("post_reset_value", value, 16'h0000);
    push_ev(1'b0, 16'h0008);
    send_frame(8'h38, 1'b1, 0);
    repeat (20) @(negedge clk);
    check16("after_reset_value", value, 16'h0008);

    repeat (20) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_events: got %0d pending expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
